fp_addsub_operand_align: RTL and testbench

//  Front end of the FP add/sub datapath, opposite end of the rounding/packing stage: unpacks two packed

---
 rtl/fp_addsub_operand_align.sv | 165 ++++++++++++++++
 tb/tb_fp_addsub_operand_align.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_operand_align.sv
// FP add/sub front end: unpack, order by magnitude, align smaller mantissa.
// Two-stage valid/ready pipeline producing guard/round/sticky bits.
module fp_addsub_operand_align #(
  parameter int DWIDTH   = 16,
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DWIDTH-1:0]   A,
  input  logic [DWIDTH-1:0]   B,
  input  logic                Ctrl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                Sa,
  output logic                Sb,
  output logic                CtrlO,
  output logic                MaxAB,
  output logic [EXPONENT-1:0] CExp,
  output logic [MANTISSA:0]   MaxM,
  output logic [MANTISSA:0]   MinM,
  output logic                G,
  output logic                R,
  output logic                S,
  output logic                InfNaN
);

  localparam int MAGW = DWIDTH - 1;
  localparam int WW   = MANTISSA + 4;
  localparam int SW   = $clog2(WW);

  localparam logic [EXPONENT-1:0] SatE =
    EXPONENT'(MANTISSA + 3);
  localparam logic [EXPONENT-1:0] ExpOne =
    EXPONENT'(1);

  logic advance;
  logic accept;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;

  logic [MAGW-1:0]     magA;
  logic [MAGW-1:0]     magB;
  logic [EXPONENT-1:0] expA;
  logic [EXPONENT-1:0] expB;
  logic                hidA;
  logic                hidB;
  logic [EXPONENT-1:0] effA;
  logic [EXPONENT-1:0] effB;
  logic [MANTISSA:0]   manA;
  logic [MANTISSA:0]   manB;
  logic                swap;
  logic [EXPONENT-1:0] maxE;
  logic [EXPONENT-1:0] minE;
  logic [EXPONENT-1:0] expDiff;
  logic [SW-1:0]       shiftC;
  logic                infC;

  assign magA = A[DWIDTH-2:0];
  assign magB = B[DWIDTH-2:0];
  assign expA = A[DWIDTH-2 -: EXPONENT];
  assign expB = B[DWIDTH-2 -: EXPONENT];
  assign hidA = |expA;
  assign hidB = |expB;
  assign effA = hidA ? expA : ExpOne;
  assign effB = hidB ? expB : ExpOne;
  assign manA = {hidA, A[MANTISSA-1:0]};
  assign manB = {hidB, B[MANTISSA-1:0]};

  // Equal magnitudes keep A as the larger operand.
  assign swap    = magB > magA;
  assign maxE    = swap ? effB : effA;
  assign minE    = swap ? effA : effB;
  assign expDiff = maxE - minE;
  assign shiftC  = (expDiff > SatE) ? SW'(SatE)
                                    : SW'(expDiff);
  assign infC    = (&expA) | (&expB);

  logic                v1;
  logic                s1Sa;
  logic                s1Sb;
  logic                s1Ctrl;
  logic                s1MaxAB;
  logic                s1Inf;
  logic [EXPONENT-1:0] s1Exp;
  logic [MANTISSA:0]   s1MaxM;
  logic [MANTISSA:0]   s1MinM;
  logic [SW-1:0]       s1Shift;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1      <= 1'b0;
      s1Sa    <= 1'b0;
      s1Sb    <= 1'b0;
      s1Ctrl  <= 1'b0;
      s1MaxAB <= 1'b0;
      s1Inf   <= 1'b0;
      s1Exp   <= '0;
      s1MaxM  <= '0;
      s1MinM  <= '0;
      s1Shift <= '0;
    end else if (advance) begin
      v1 <= accept;
      if (accept) begin
        s1Sa    <= A[DWIDTH-1];
        s1Sb    <= B[DWIDTH-1];
        s1Ctrl  <= Ctrl;
        s1MaxAB <= swap;
        s1Inf   <= infC;
        s1Exp   <= maxE;
        s1MaxM  <= swap ? manB : manA;
        s1MinM  <= swap ? manA : manB;
        s1Shift <= shiftC;
      end
    end
  end

  logic [WW-1:0]   ext;
  logic [2*WW-1:0] wide;
  logic [WW-1:0]   w;
  logic            lost;

  // Low half of the wide shift collects everything pushed past bit 0.
  assign ext  = {s1MinM, 3'b000};
  assign wide = {ext, {WW{1'b0}}} >> s1Shift;
  assign w    = wide[2*WW-1:WW];
  assign lost = |wide[WW-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      Sa        <= 1'b0;
      Sb        <= 1'b0;
      CtrlO     <= 1'b0;
      MaxAB     <= 1'b0;
      InfNaN    <= 1'b0;
      CExp      <= '0;
      MaxM      <= '0;
      MinM      <= '0;
      G         <= 1'b0;
      R         <= 1'b0;
      S         <= 1'b0;
    end else if (advance) begin
      out_valid <= v1;
      if (v1) begin
        Sa     <= s1Sa;
        Sb     <= s1Sb;
        CtrlO  <= s1Ctrl;
        MaxAB  <= s1MaxAB;
        InfNaN <= s1Inf;
        CExp   <= s1Exp;
        MaxM   <= s1MaxM;
        MinM   <= w[WW-1:3];
        G      <= w[2];
        R      <= w[1];
        S      <= w[0] | lost;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_operand_align.sv
// Bench for fp_addsub_operand_align: vector table plus scoreboard.
// Covers ordering, alignment, sticky, stalls and reset flush.
module tb_fp_addsub_operand_align;

  typedef struct packed {
    logic        sa;
    logic        sb;
    logic        ctrl;
    logic        maxab;
    logic [4:0]  cexp;
    logic [10:0] maxm;
    logic [10:0] minm;
    logic        g;
    logic        r;
    logic        s;
    logic        inf;
  } out_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    out_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Ctrl = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        Sa, Sb, CtrlO, MaxAB;
  logic [4:0]  CExp;
  logic [10:0] MaxM, MinM;
  logic        G, R, S, InfNaN;

  int   nCmp = 0;
  int   nErr = 0;
  out_t sb[$];
  vec_t tbl[12];
  vec_t none;
  logic acc;

  fp_addsub_operand_align dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Ctrl(Ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sa(Sa), .Sb(Sb), .CtrlO(CtrlO), .MaxAB(MaxAB),
    .CExp(CExp), .MaxM(MaxM), .MinM(MinM),
    .G(G), .R(R), .S(S), .InfNaN(InfNaN)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [15:0] a, input logic [15:0] b,
    input logic c, input logic mab,
    input logic [4:0] ce, input logic [10:0] mx,
    input logic [10:0] mn, input logic g,
    input logic r, input logic s, input logic inf);
    vec_t v;
    v.a = a; v.b = b; v.c = c;
    v.e = '{sa: a[15], sb: b[15], ctrl: c,
            maxab: mab, cexp: ce, maxm: mx,
            minm: mn, g: g, r: r, s: s, inf: inf};
    return v;
  endfunction

  function automatic out_t actual();
    out_t o;
    o = '{sa: Sa, sb: Sb, ctrl: CtrlO,
          maxab: MaxAB, cexp: CExp, maxm: MaxM,
          minm: MinM, g: G, r: R, s: S, inf: InfNaN};
    return o;
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      out_t a;
      a = actual();
      nCmp++;
      if (sb.size() == 0) begin
        nErr++;
        $display("FAIL unexpected output %h", a);
      end else begin
        out_t e;
        e = sb.pop_front();
        if (a !== e) begin
          nErr++;
          $display(
            "FAIL result got mab=%b ce=%h mx=%h mn=%h grs=%b%b%b inf=%b s=%b%b%b want mab=%b ce=%h mx=%h mn=%h grs=%b%b%b inf=%b s=%b%b%b",
            a.maxab, a.cexp, a.maxm, a.minm, a.g, a.r, a.s,
            a.inf, a.sa, a.sb, a.ctrl,
            e.maxab, e.cexp, e.maxm, e.minm, e.g, e.r, e.s,
            e.inf, e.sa, e.sb, e.ctrl);
        end
      end
    end
  end

  task automatic cycle(input logic v, input vec_t x,
                       input logic ordy, output logic ok);
    @(posedge clk);
    #1;
    in_valid  = v;
    A         = x.a;
    B         = x.b;
    Ctrl      = x.c;
    out_ready = ordy;
    #1;
    ok = v && in_ready;
    if (ok) sb.push_back(x.e);
  endtask

  task automatic send(input vec_t x, input logic ordy);
    logic ok;
    int n;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      cycle(1'b1, x, ordy, ok);
      n++;
    end
    if (!ok) begin
      nCmp++;
      nErr++;
      $display("FAIL send timeout got busy want accept");
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic ok;
    for (int i = 0; i < n; i++) cycle(1'b0, none, ordy, ok);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      idle(1, 1'b1);
      n++;
    end
    idle(2, 1'b1);
    check("drain queue empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    none = mk(16'h0, 16'h0, 1'b0, 1'b0, 5'd0,
              11'h0, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[0]  = mk(16'h3C00, 16'h4000, 0, 1, 5'd16,
                 11'h400, 11'h200, 0, 0, 0, 0);
    tbl[1]  = mk(16'h4000, 16'h3C01, 1, 0, 5'd16,
                 11'h400, 11'h200, 1, 0, 0, 0);
    tbl[2]  = mk(16'h7800, 16'h3C00, 0, 0, 5'd30,
                 11'h400, 11'h000, 0, 0, 1, 0);
    tbl[3]  = mk(16'h0001, 16'h0400, 0, 1, 5'd1,
                 11'h400, 11'h001, 0, 0, 0, 0);
    tbl[4]  = mk(16'h3C00, 16'h3C00, 0, 0, 5'd15,
                 11'h400, 11'h400, 0, 0, 0, 0);
    tbl[5]  = mk(16'h7C00, 16'h3C00, 0, 0, 5'd31,
                 11'h400, 11'h000, 0, 0, 1, 1);
    tbl[6]  = mk(16'hC000, 16'h3C00, 1, 0, 5'd16,
                 11'h400, 11'h200, 0, 0, 0, 0);
    tbl[7]  = mk(16'h4800, 16'h3FFF, 0, 0, 5'd18,
                 11'h400, 11'h0FF, 1, 1, 1, 0);
    tbl[8]  = mk(16'h6800, 16'h3801, 0, 0, 5'd26,
                 11'h400, 11'h000, 0, 1, 1, 0);
    tbl[9]  = mk(16'h0003, 16'h0002, 1, 0, 5'd1,
                 11'h003, 11'h002, 0, 0, 0, 0);
    tbl[10] = mk(16'h0000, 16'h5000, 0, 1, 5'd20,
                 11'h400, 11'h000, 0, 0, 0, 0);
    tbl[11] = mk(16'h3C00, 16'hBC00, 1, 0, 5'd15,
                 11'h400, 11'h400, 0, 0, 0, 0);

    rst = 1'b0;
    idle(3, 1'b0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset outputs", 64'(actual()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 12; i++) send(tbl[i], 1'b1);
    drain();

    for (int i = 11; i >= 0; i--) begin
      send(tbl[i], 1'b1);
      if (i % 3 == 0) idle(1, 1'b1);
    end
    drain();

    cycle(1'b1, tbl[0], 1'b0, acc);
    check("stall accept 1", 64'(acc), 64'd1);
    cycle(1'b1, tbl[1], 1'b0, acc);
    check("stall accept 2", 64'(acc), 64'd1);
    cycle(1'b1, tbl[2], 1'b0, acc);
    check("stall in_ready low", 64'(acc), 64'd0);
    check("stall out_valid", 64'(out_valid), 64'd1);
    send(tbl[2], 1'b1);
    send(tbl[3], 1'b1);
    drain();

    cycle(1'b1, tbl[5], 1'b0, acc);
    cycle(1'b1, tbl[7], 1'b0, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    idle(6, 1'b1);

    send(tbl[5], 1'b1);
    drain();
    check("inf flag held", 64'(InfNaN), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout got running want done");
    $fatal(1);
  end

endmodule
